// File: rtl/debug_slave_sysclk_dispatch_pkg.sv
// Shared types and default channel codes for the system-clock side of the debug slave.
// The channel code is the instruction value latched from the tck domain.
package debug_slave_sysclk_dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    WAIT_ACK = 2'd2
  } dispatch_state_e;

  localparam int unsigned BREAK_A   = 0;
  localparam int unsigned OCIMEM    = 1;
  localparam int unsigned TRACECTRL = 2;
  localparam int unsigned TRACEMEM  = 3;

endpackage

// File: rtl/debug_slave_sysclk_dispatch_sync_edge.sv
// Synchroniser chain plus registered rising-edge detect for one tck-domain strobe.
// Rise on async_in appears on pulse SYNC_STAGES+1 clocks later, for one clock.
module debug_strobe_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        PREV_RST    = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] vld_q;
  logic                   prev_q;
  logic                   pulse_q;

  // The previous-value flop only follows the chain once the chain holds real
  // samples, so a level held high through reset never looks like a rise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      vld_q   <= '0;
      prev_q  <= PREV_RST;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
      vld_q   <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      pulse_q <= vld_q[SYNC_STAGES-1] & sync_q[SYNC_STAGES-1] & ~prev_q;
      if (vld_q[SYNC_STAGES-1]) prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/debug_slave_sysclk_dispatch.sv
// System-clock dispatcher of the debug slave: latches ir/jdo from the tck domain
// and issues one-hot take_action / take_no_action commands to NUM_CH consumers.
module debug_slave_sysclk_dispatch
  import debug_slave_sysclk_dispatch_pkg::*;
#(
  parameter int unsigned IR_W        = 2,
  parameter int unsigned DR_W        = 38,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned ACT_BIT     = 37,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HANDSHAKE   = 0,
  parameter int unsigned CNT_W       = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vs_uir,
  input  logic              vs_udr,
  input  logic [IR_W-1:0]   ir_in,
  input  logic [DR_W-1:0]   sr,
  input  logic [NUM_CH-1:0] ch_ack,
  output logic [DR_W-1:0]   jdo,
  output logic [NUM_CH-1:0] take_action,
  output logic [NUM_CH-1:0] take_no_action,
  output logic              busy,
  output logic [CNT_W-1:0]  overrun_cnt,
  output logic [CNT_W-1:0]  illegal_cnt
);

  localparam logic [IR_W:0]     NUM_CH_W = (IR_W+1)'(NUM_CH);
  localparam logic [NUM_CH-1:0] CH_ONE   = NUM_CH'(1);

  logic              uir_p;
  logic              udr_p;
  logic [IR_W-1:0]   ir_q;
  logic [IR_W-1:0]   cmd_ch_q;
  logic              cmd_act_q;
  dispatch_state_e   state_q;
  dispatch_state_e   state_d;
  logic [NUM_CH-1:0] act_q;
  logic [NUM_CH-1:0] act_d;
  logic [NUM_CH-1:0] nact_q;
  logic [NUM_CH-1:0] nact_d;
  logic [NUM_CH-1:0] ch_onehot;
  logic              ch_legal;
  logic              accept;
  logic              drop;
  logic              illegal;

  debug_strobe_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .PREV_RST    (1'b1)
  ) u_sync_uir (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (vs_uir),
    .pulse    (uir_p)
  );

  debug_strobe_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .PREV_RST    (1'b1)
  ) u_sync_udr (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (vs_udr),
    .pulse    (udr_p)
  );

  // Out-of-range codes shift the one-hot off the top, giving no strobe at all.
  assign ch_onehot = CH_ONE << cmd_ch_q;
  assign ch_legal  = ({1'b0, cmd_ch_q} < NUM_CH_W);

  always_comb begin
    state_d = state_q;
    act_d   = '0;
    nact_d  = '0;
    accept  = 1'b0;
    drop    = 1'b0;
    illegal = 1'b0;
    case (state_q)
      IDLE: begin
        if (udr_p) begin
          accept  = 1'b1;
          state_d = DISPATCH;
        end
      end
      DISPATCH: begin
        drop = udr_p;
        if (!ch_legal) begin
          illegal = 1'b1;
          state_d = IDLE;
        end else begin
          act_d   = ch_onehot & {NUM_CH{cmd_act_q}};
          nact_d  = ch_onehot & {NUM_CH{~cmd_act_q}};
          state_d = (HANDSHAKE != 0) ? WAIT_ACK : IDLE;
        end
      end
      WAIT_ACK: begin
        drop = udr_p;
        if ((ch_ack & ch_onehot) != '0) begin
          state_d = IDLE;
        end else begin
          act_d  = act_q;
          nact_d = nact_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ir_q        <= '0;
      cmd_ch_q    <= '0;
      cmd_act_q   <= 1'b0;
      jdo         <= '0;
      act_q       <= '0;
      nact_q      <= '0;
      overrun_cnt <= '0;
      illegal_cnt <= '0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      nact_q  <= nact_d;
      if (uir_p) ir_q <= ir_in;
      // ir_q here is the pre-update value when uir_p and udr_p coincide.
      if (accept) begin
        jdo       <= sr;
        cmd_ch_q  <= ir_q;
        cmd_act_q <= sr[ACT_BIT];
      end
      if (drop && (overrun_cnt != '1)) overrun_cnt <= overrun_cnt + CNT_W'(1);
      if (illegal && (illegal_cnt != '1)) illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

  assign take_action    = act_q;
  assign take_no_action = nact_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_debug_slave_sysclk_dispatch.sv
// Bench for debug_slave_sysclk_dispatch: three configurations share one stimulus
// stream and are compared every clock against an edge-numbered command model.
module tb_debug_slave_sysclk_dispatch;

  localparam int N   = 2;
  localparam int INF = 32'h3fff_ffff;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        vs_uir = 1'b0;
  logic        vs_udr = 1'b1;
  logic [1:0]  ir_in = 2'd0;
  logic [37:0] sr = '0;
  logic [3:0]  ch_ack = 4'd0;

  logic [37:0] jdo0, jdo1, jdo2;
  logic [3:0]  ta0, tna0, ta1, tna1;
  logic [2:0]  ta2, tna2;
  logic        busy0, busy1, busy2;
  logic [7:0]  ovr0, ovr1, ovr2, ill0, ill1, ill2;

  logic [37:0] jdo_a [3];
  logic [3:0]  ta_a  [3];
  logic [3:0]  tna_a [3];
  logic        busy_a[3];
  logic [7:0]  ovr_a [3];
  logic [7:0]  ill_a [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  debug_slave_sysclk_dispatch #(.NUM_CH(4), .HANDSHAKE(0)) u_hs0 (
    .clk(clk), .reset_n(reset_n), .vs_uir(vs_uir), .vs_udr(vs_udr), .ir_in(ir_in),
    .sr(sr), .ch_ack(ch_ack), .jdo(jdo0), .take_action(ta0), .take_no_action(tna0),
    .busy(busy0), .overrun_cnt(ovr0), .illegal_cnt(ill0));

  debug_slave_sysclk_dispatch #(.NUM_CH(4), .HANDSHAKE(1)) u_hs1 (
    .clk(clk), .reset_n(reset_n), .vs_uir(vs_uir), .vs_udr(vs_udr), .ir_in(ir_in),
    .sr(sr), .ch_ack(ch_ack), .jdo(jdo1), .take_action(ta1), .take_no_action(tna1),
    .busy(busy1), .overrun_cnt(ovr1), .illegal_cnt(ill1));

  debug_slave_sysclk_dispatch #(.NUM_CH(3), .HANDSHAKE(0)) u_ch3 (
    .clk(clk), .reset_n(reset_n), .vs_uir(vs_uir), .vs_udr(vs_udr), .ir_in(ir_in),
    .sr(sr), .ch_ack(ch_ack[2:0]), .jdo(jdo2), .take_action(ta2), .take_no_action(tna2),
    .busy(busy2), .overrun_cnt(ovr2), .illegal_cnt(ill2));

  assign jdo_a[0] = jdo0;  assign jdo_a[1] = jdo1;  assign jdo_a[2] = jdo2;
  assign ta_a[0]  = ta0;   assign ta_a[1]  = ta1;   assign ta_a[2]  = {1'b0, ta2};
  assign tna_a[0] = tna0;  assign tna_a[1] = tna1;  assign tna_a[2] = {1'b0, tna2};
  assign busy_a[0] = busy0; assign busy_a[1] = busy1; assign busy_a[2] = busy2;
  assign ovr_a[0] = ovr0;  assign ovr_a[1] = ovr1;  assign ovr_a[2] = ovr2;
  assign ill_a[0] = ill0;  assign ill_a[1] = ill1;  assign ill_a[2] = ill2;

  // Model: each accepted command is a record stamped with the edge number it was
  // accepted on; outputs follow from arithmetic on edge numbers.
  int          hs_m [3] = '{0, 1, 0};
  int          nch_m[3] = '{4, 4, 3};
  int          cyc;
  bit          udr_h[$];
  bit          uir_h[$];
  int          m_ir;
  bit          m_active[3];
  int          m_e[3];
  int          m_done[3];
  int          m_ch[3];
  bit          m_act[3];
  logic [37:0] m_jdo[3];
  int          m_ovr[3];
  int          m_ill[3];

  task automatic check(input string name, input int inst, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s inst=%0d edge=%0d got=%0h exp=%0h", name, inst, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0;
    m_ir = 0;
    udr_h.delete();
    uir_h.delete();
    for (int k = 0; k < N + 3; k++) begin
      udr_h.push_back(vs_udr);
      uir_h.push_back(vs_uir);
    end
    for (int i = 0; i < 3; i++) begin
      m_active[i] = 1'b0;
      m_e[i] = 0;
      m_done[i] = 0;
      m_ch[i] = 0;
      m_act[i] = 1'b0;
      m_jdo[i] = '0;
      m_ovr[i] = 0;
      m_ill[i] = 0;
    end
  endtask

  task automatic model_step();
    bit udr_p, uir_p, legal;
    cyc++;
    udr_h.push_front(vs_udr);
    uir_h.push_front(vs_uir);
    // A rise sampled at edge k shows as a pulse consumed at edge k+N+1.
    udr_p = udr_h[N+1] && !udr_h[N+2];
    uir_p = uir_h[N+1] && !uir_h[N+2];
    void'(udr_h.pop_back());
    void'(uir_h.pop_back());
    for (int i = 0; i < 3; i++) begin
      if (m_active[i] && hs_m[i] == 1 && m_done[i] == INF && cyc >= m_e[i] + 2 &&
          ch_ack[m_ch[i]])
        m_done[i] = cyc;
      if (udr_p) begin
        if (m_active[i] && (cyc - 1) >= m_e[i] && (cyc - 1) < m_done[i]) begin
          if (m_ovr[i] < 255) m_ovr[i]++;
        end else begin
          m_active[i] = 1'b1;
          m_e[i] = cyc;
          m_ch[i] = m_ir;
          m_act[i] = sr[37];
          m_jdo[i] = sr;
          legal = (m_ir < nch_m[i]);
          m_done[i] = (hs_m[i] == 1 && legal) ? INF : cyc + 1;
        end
      end
      if (m_active[i] && cyc == m_e[i] + 1 && m_ch[i] >= nch_m[i] && m_ill[i] < 255)
        m_ill[i]++;
    end
    if (uir_p) m_ir = int'(ir_in);
  endtask

  always begin
    @(posedge clk);
    if (reset_n) begin
      #1;
      model_step();
      for (int i = 0; i < 3; i++) begin
        bit on, bsy;
        logic [3:0] oh;
        int s_end;
        s_end = (hs_m[i] == 1) ? m_done[i] : m_e[i] + 2;
        bsy = m_active[i] && cyc >= m_e[i] && cyc < m_done[i];
        on  = m_active[i] && m_ch[i] < nch_m[i] && cyc >= m_e[i] + 1 && cyc < s_end;
        oh  = 4'b0001 << m_ch[i];
        check("jdo", i, 64'(jdo_a[i]), 64'(m_jdo[i]));
        check("take_action", i, 64'(ta_a[i]), 64'((on && m_act[i]) ? oh : 4'b0));
        check("take_no_action", i, 64'(tna_a[i]), 64'((on && !m_act[i]) ? oh : 4'b0));
        check("busy", i, 64'(busy_a[i]), 64'(bsy));
        check("overrun_cnt", i, 64'(ovr_a[i]), 64'(m_ovr[i]));
        check("illegal_cnt", i, 64'(ill_a[i]), 64'(m_ill[i]));
      end
    end
  end

  task automatic pulse_uir(input logic [1:0] v);
    @(negedge clk);
    ir_in = v;
    vs_uir = 1'b1;
    repeat (4) @(negedge clk);
    vs_uir = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Raises vs_udr at a negedge and watches instance 0's strobes for 10 clocks.
  task automatic fire_udr(input logic [37:0] v, output int first, output int cnt,
                          output logic [3:0] s_ta, output logic [3:0] s_tna);
    first = 0;
    cnt = 0;
    s_ta = '0;
    s_tna = '0;
    @(negedge clk);
    sr = v;
    vs_udr = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 4) vs_udr = 1'b0;
      if ((ta_a[0] | tna_a[0]) != 4'b0) begin
        if (first == 0) first = k;
        cnt++;
        s_ta  = s_ta | ta_a[0];
        s_tna = s_tna | tna_a[0];
      end
    end
  endtask

  initial begin
    int first, cnt;
    logic [3:0] s_ta, s_tna;

    // vs_udr held high through reset release must not dispatch.
    repeat (3) @(negedge clk);
    model_reset();
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_busy", 0, 64'(busy_a[0]), 64'd0);
    check("rst_take_action", 0, 64'(ta_a[0]), 64'd0);
    check("rst_jdo", 0, 64'(jdo_a[0]), 64'd0);
    vs_udr = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_fall_jdo", 1, 64'(jdo_a[1]), 64'd0);

    ch_ack = 4'hF;
    pulse_uir(2'd2);
    fire_udr(38'h20_0000_00AB, first, cnt, s_ta, s_tna);
    check("lat_first", 0, 64'(first), 64'(N + 3));
    check("lat_width", 0, 64'(cnt), 64'd1);
    check("act_ch2", 0, 64'(s_ta), 64'h4);
    check("jdo_ab", 0, 64'(jdo_a[0]), 64'h20_0000_00AB);

    pulse_uir(2'd1);
    fire_udr(38'h00_0000_0055, first, cnt, s_ta, s_tna);
    check("noact_ch1", 0, 64'(s_tna), 64'h2);
    check("noact_ta_quiet", 0, 64'(s_ta), 64'h0);
    check("noact_width", 0, 64'(cnt), 64'd1);

    ch_ack = 4'h0;
    pulse_uir(2'd0);
    fire_udr(38'h20_0000_1234, first, cnt, s_ta, s_tna);
    check("hs_hold", 1, 64'(ta_a[1]), 64'h1);
    check("hs_busy", 1, 64'(busy_a[1]), 64'd1);
    fire_udr(38'h00_0000_0BAD, first, cnt, s_ta, s_tna);
    check("hs_overrun", 1, 64'(ovr_a[1]), 64'd1);
    check("hs_jdo_kept", 1, 64'(jdo_a[1]), 64'h20_0000_1234);
    @(negedge clk);
    ch_ack = 4'b0010;
    repeat (3) @(negedge clk);
    check("hs_wrong_ack", 1, 64'(ta_a[1]), 64'h1);
    ch_ack = 4'b0001;
    @(negedge clk);
    ch_ack = 4'b0000;
    check("hs_ack_clear", 1, 64'(ta_a[1]), 64'h0);
    check("hs_ack_idle", 1, 64'(busy_a[1]), 64'd0);

    ch_ack = 4'hF;
    pulse_uir(2'd3);
    fire_udr(38'h20_0000_0003, first, cnt, s_ta, s_tna);
    check("illegal_one", 2, 64'(ill_a[2]), 64'd1);
    for (int r = 0; r < 299; r++) fire_udr(38'(r), first, cnt, s_ta, s_tna);
    check("illegal_sat", 2, 64'(ill_a[2]), 64'd255);
    check("illegal_none4", 0, 64'(ill_a[0]), 64'd0);

    // Reset in the middle of a held command.
    ch_ack = 4'h0;
    pulse_uir(2'd2);
    fire_udr(38'h20_0000_0042, first, cnt, s_ta, s_tna);
    check("pre_rst_hold", 1, 64'(ta_a[1]), 64'h4);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_async_drop", 1, 64'(ta_a[1]), 64'h0);
    check("rst_async_busy", 1, 64'(busy_a[1]), 64'd0);
    repeat (3) @(negedge clk);
    model_reset();
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    pulse_uir(2'd1);
    fire_udr(38'h20_0000_0777, first, cnt, s_ta, s_tna);
    check("post_rst_dispatch", 1, 64'(ta_a[1]), 64'h2);
    ch_ack = 4'hF;
    repeat (4) @(negedge clk);

    for (int k = 0; k < 2500; k++) begin
      @(negedge clk);
      if ($urandom_range(4) == 0) vs_udr = ~vs_udr;
      if ($urandom_range(6) == 0) vs_uir = ~vs_uir;
      ir_in = 2'($urandom_range(3));
      sr = {6'($urandom), 32'($urandom)};
      ch_ack = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
    end
    vs_udr = 1'b0;
    vs_uir = 1'b0;
    ch_ack = 4'hF;
    repeat (12) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
